// File: rtl/memory_access_pkg.sv
// Shared types for the MIPS memory stage: opcodes, exception flags, stage payloads
// and the bus-handshake state encoding.
package memory_access_pkg;

   typedef enum logic [3:0] {
      OP_NOP = 4'd0,
      OP_ALU = 4'd1,
      OP_LB  = 4'd2,
      OP_LBU = 4'd3,
      OP_LH  = 4'd4,
      OP_LHU = 4'd5,
      OP_LW  = 4'd6,
      OP_SB  = 4'd7,
      OP_SH  = 4'd8,
      OP_SW  = 4'd9
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      HOLD = 2'd3
   } mem_state_t;

   localparam logic [1:0] MSIZE_B = 2'd0;
   localparam logic [1:0] MSIZE_H = 2'd1;
   localparam logic [1:0] MSIZE_W = 2'd2;

   typedef struct packed {
      logic ADEL;
      logic ADES;
      logic OV;
      logic RI;
      logic SYS;
   } exp_t;

   typedef struct packed {
      op_t         OP;
      logic [31:0] valA;
      logic [31:0] valB;
      logic        rm;
      logic        wm;
      logic [4:0]  regw;
      logic [31:0] pc;
      exp_t        exp;
      logic        hi_w;
      logic        lo_w;
   } M_type;

   typedef struct packed {
      logic [31:0] valA;
      logic [31:0] valB;
      logic [4:0]  regw;
      logic        hi_w;
      logic        lo_w;
      logic [31:0] pc;
      exp_t        exp;
      logic [31:0] badvaddr;
   } W_type;

   function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
      return {{24{sgn & b[7]}}, b};
   endfunction

   function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
      return {{16{sgn & h[15]}}, h};
   endfunction

endpackage

// File: rtl/memory_access_mem_align.sv
// Combinational lane logic: store strobes/replication, load extraction/extension
// and alignment checking for one memory op.
module mem_align
   import memory_access_pkg::*;
(
   input  op_t         i_op,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_valB,
   input  logic [31:0] i_raw,
   output logic [3:0]  o_strobe,
   output logic [31:0] o_wdata,
   output logic [1:0]  o_size,
   output logic [31:0] o_rdata_ext,
   output logic        o_misaligned
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_raw[{i_addr, 3'b000} +: 8];
   assign w_half = i_addr[1] ? i_raw[31:16] : i_raw[15:0];

   // Per-opcode lane selection
   always_comb begin
      o_strobe     = 4'b0000;
      o_wdata      = i_valB;
      o_size       = MSIZE_W;
      o_rdata_ext  = i_raw;
      o_misaligned = 1'b0;
      case (i_op)
         OP_LB, OP_LBU: begin
            o_size      = MSIZE_B;
            o_rdata_ext = ext8(w_byte, i_op == OP_LB);
         end
         OP_LH, OP_LHU: begin
            o_size       = MSIZE_H;
            o_rdata_ext  = ext16(w_half, i_op == OP_LH);
            o_misaligned = i_addr[0];
         end
         OP_LW: begin
            o_misaligned = (i_addr != 2'b00);
         end
         OP_SB: begin
            o_size   = MSIZE_B;
            o_strobe = 4'b0001 << i_addr;
            o_wdata  = {4{i_valB[7:0]}};
         end
         OP_SH: begin
            o_size       = MSIZE_H;
            o_strobe     = 4'b0011 << {i_addr[1], 1'b0};
            o_wdata      = {2{i_valB[15:0]}};
            o_misaligned = i_addr[0];
         end
         OP_SW: begin
            o_strobe     = 4'b1111;
            o_misaligned = (i_addr != 2'b00);
         end
         default: begin
            o_size = MSIZE_W;
         end
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// MIPS memory stage: runs the data-bus handshake for loads/stores, stalls while a
// transaction is outstanding, and builds the writeback payload.
module memory_access
   import memory_access_pkg::*;
#(
   parameter int KSEG1_UNCACHED = 1
)(
   input  logic        clk,
   input  logic        resetn,
   input  M_type       M,
   input  logic        stall_ext,
   output logic        pcm,
   output W_type       W_pre,
   output logic        dreq_valid,
   output logic [31:0] dreq_addr,
   output logic [1:0]  dreq_size,
   output logic [3:0]  dreq_strobe,
   output logic [31:0] dreq_data,
   output logic        dreq_uncached,
   input  logic        dresp_addr_ok,
   input  logic        dresp_data_ok,
   input  logic [31:0] dresp_data
);

   mem_state_t  r_state;
   mem_state_t  w_next;
   logic [31:0] r_rdata;
   logic [31:0] w_raw;
   logic [3:0]  w_strobe;
   logic [31:0] w_wdata;
   logic [1:0]  w_size;
   logic [31:0] w_rdata_ext;
   logic        w_mis;
   logic        w_mem;
   logic        w_req;
   logic        w_bad;
   logic        w_valid;
   logic        w_pcm;
   logic        w_capture;

   assign w_mem = M.rm | M.wm;
   assign w_req = w_mem & ~w_mis & (M.exp == '0);
   assign w_bad = w_mem & w_mis;
   // Captured word survives the freeze; live bus data is only valid on data_ok.
   assign w_raw = (r_state == HOLD) ? r_rdata : dresp_data;

   mem_align u_align (
      .i_op         (M.OP),
      .i_addr       (M.valA[1:0]),
      .i_valB       (M.valB),
      .i_raw        (w_raw),
      .o_strobe     (w_strobe),
      .o_wdata      (w_wdata),
      .o_size       (w_size),
      .o_rdata_ext  (w_rdata_ext),
      .o_misaligned (w_mis)
   );

   // State and captured load data
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_rdata <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_capture) begin
            r_rdata <= dresp_data;
         end else begin
            r_rdata <= r_rdata;
         end
      end
   end

   // Handshake next-state, request valid and stall request
   always_comb begin
      w_next    = r_state;
      w_valid   = 1'b0;
      w_pcm     = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         IDLE, ADDR: begin
            if (w_req || (r_state == ADDR)) begin
               w_valid = 1'b1;
               if (dresp_addr_ok && dresp_data_ok) begin
                  w_capture = stall_ext;
                  w_next    = stall_ext ? HOLD : IDLE;
               end else if (dresp_addr_ok) begin
                  w_pcm  = 1'b1;
                  w_next = DATA;
               end else begin
                  w_pcm  = 1'b1;
                  w_next = ADDR;
               end
            end else begin
               w_next = IDLE;
            end
         end
         DATA: begin
            if (dresp_data_ok) begin
               w_capture = stall_ext;
               w_next    = stall_ext ? HOLD : IDLE;
            end else begin
               w_pcm  = 1'b1;
               w_next = DATA;
            end
         end
         HOLD: begin
            w_next = stall_ext ? HOLD : IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   assign pcm           = w_pcm;
   assign dreq_valid    = w_valid;
   assign dreq_addr     = w_valid ? M.valA : 32'd0;
   assign dreq_size     = w_valid ? w_size : 2'd0;
   assign dreq_strobe   = (w_valid && M.wm) ? w_strobe : 4'b0000;
   assign dreq_data     = (w_valid && M.wm) ? w_wdata : 32'd0;
   assign dreq_uncached = (KSEG1_UNCACHED != 0) ? (w_valid & (M.valA[31:29] == 3'b101)) : 1'b0;

   // Writeback payload
   always_comb begin
      W_pre          = '0;
      W_pre.valA     = (M.rm && !w_mis && (M.exp == '0)) ? w_rdata_ext : M.valA;
      W_pre.valB     = M.valB;
      W_pre.regw     = w_bad ? 5'd0 : M.regw;
      W_pre.hi_w     = M.hi_w;
      W_pre.lo_w     = M.lo_w;
      W_pre.pc       = M.pc;
      W_pre.exp      = M.exp;
      W_pre.exp.ADEL = M.exp.ADEL | (M.rm & w_mis);
      W_pre.exp.ADES = M.exp.ADES | (M.wm & w_mis);
      W_pre.badvaddr = w_bad ? M.valA : 32'd0;
   end

endmodule
